// File: rtl/fir2d_systolic_param.sv
// fir2d_systolic_param: K x K 2-D FIR, K systolic MAC rows, round-to-nearest, clamp, deferred coefficient commit
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, pixels      row pixels (row r at [r*PIX_W +: PIX_W]); zeroed when in_valid=0
//   coef_we/addr/wdata    shadow coefficient write (row-major r*K+k, addresses >= K*K ignored)
//   coef_commit           request shadow -> active copy once the pipeline is empty
//   coef_pending          commit requested but not yet applied
//   out_pixel, out_valid  filtered pixel, K+4 cycles after its newest input sample
//   sat_count             clamped-output counter, present only with FIR2D_SAT_CNT_EN defined
module fir2d_systolic_param #(
  parameter int K      = 5,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 17,
  parameter int FRAC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [K*PIX_W-1:0]         pixels,
  input  logic                       coef_we,
  input  logic [$clog2(K*K)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  input  logic                       coef_commit,
  output logic                       coef_pending,
  output logic [PIX_W-1:0]           out_pixel,
  output logic                       out_valid
`ifdef FIR2D_SAT_CNT_EN
  , output logic [15:0]              sat_count
`endif
);
  localparam int ACC_W = PIX_W + COEF_W + 2*$clog2(K) + 1;
  localparam int LAT   = K + 4;
  localparam int AW    = $clog2(K*K);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] MAXP = ACC_W'((1 << PIX_W) - 1);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_nxt;
  logic [PIX_W-1:0] d [K][2*K-1];
  logic signed [ACC_W-1:0] m [K][K];
  logic signed [ACC_W-1:0] a [K][K];
  logic signed [ACC_W-1:0] row_sum, sum_r, rnd;
  logic signed [COEF_W-1:0] shadow [K*K];
  logic signed [COEF_W-1:0] shadow_nxt [K*K];
  logic signed [COEF_W-1:0] active [K*K];
  logic [LAT-1:0] vsr;
  logic empty, copy, lo, hi;
  logic [PIX_W-1:0] clamp_pix;
  // Tap k sees the pixel 2k registers down the delay line while the partial sum
  // advances one register per tap, so tap k multiplies the sample k cycles older.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int j = 0; j < 2*K-1; j++) d[r][j] <= '0;
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K; k++) begin
          m[r][k] <= '0;
          a[r][k] <= '0;
        end
      sum_r     <= '0;
      vsr       <= '0;
      out_pixel <= '0;
    end else begin
      for (int r = 0; r < K; r++) begin
        d[r][0] <= in_valid ? pixels[r*PIX_W +: PIX_W] : '0;
        for (int j = 1; j < 2*K-1; j++) d[r][j] <= d[r][j-1];
        for (int k = 0; k < K; k++)
          m[r][k] <= ACC_W'($signed({1'b0, d[r][2*k]})) * ACC_W'(active[r*K+k]);
        a[r][0] <= m[r][0];
        for (int k = 1; k < K; k++) a[r][k] <= a[r][k-1] + m[r][k];
      end
      sum_r     <= row_sum;
      vsr       <= {vsr[LAT-2:0], in_valid};
      out_pixel <= clamp_pix;
    end
  always_comb begin
    row_sum = '0;
    for (int r = 0; r < K; r++) row_sum = row_sum + a[r][K-1];
  end
  always_comb begin
    rnd       = (sum_r + HALF) >>> FRAC_W;
    lo        = rnd < 0;
    hi        = rnd > MAXP;
    clamp_pix = lo ? '0 : hi ? '1 : rnd[PIX_W-1:0];
  end
  assign out_valid = vsr[LAT-1];
  // A write landing on the copy edge must be part of the copy, so both banks load from shadow_nxt.
  always_comb
    for (int i = 0; i < K*K; i++)
      shadow_nxt[i] = (coef_we && coef_addr == AW'(i)) ? coef_wdata : shadow[i];
  assign empty = !in_valid && vsr == '0;
  assign copy  = empty && (state == PENDING || coef_commit);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < K*K; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      shadow <= shadow_nxt;
      if (copy) active <= shadow_nxt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((coef_commit && !empty) ? PENDING : IDLE)
                              : (empty ? IDLE : PENDING);
  always_comb coef_pending = state == PENDING;
`ifdef FIR2D_SAT_CNT_EN
  // Counted on the edge that registers the clamped result, aligned with its out_valid.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_count <= '0;
    else if (vsr[LAT-2] && (lo || hi) && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
`endif
endmodule
